// File: rtl/pc_fetch_ras_if.sv
// rtl/pc_fetch_ras_if.sv - control and status bundle between the fetch PC/RAS block and the pipeline
interface pc_fetch_ras_if #(
  parameter int WIDTH     = 64,
  parameter int RAS_DEPTH = 8
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] flush_target;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             call_push;
  logic             ret_pop;
  logic [WIDTH-1:0] currPC;
  logic [WIDTH-1:0] pc_plus_inc;
  logic [WIDTH-1:0] ras_top;
  logic [CW-1:0]    ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;
  logic             ras_overflow;

  modport master (
    output stall, flush, flush_target, branch_taken, branch_target, call_push, ret_pop,
    input  currPC, pc_plus_inc, ras_top, ras_count, ras_empty, ras_full,
           ras_underflow, ras_overflow
  );

  modport slave (
    input  stall, flush, flush_target, branch_taken, branch_target, call_push, ret_pop,
    output currPC, pc_plus_inc, ras_top, ras_count, ras_empty, ras_full,
           ras_underflow, ras_overflow
  );
endinterface

// File: rtl/pc_fetch_ras.sv
// rtl/pc_fetch_ras.sv - fetch program counter with circular return-address stack
module pc_fetch_ras #(
  parameter int               WIDTH     = 64,
  parameter int               INC       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 8
) (
  input logic          clk,
  input logic          rst,
  pc_fetch_ras_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             uf_q, uf_d;
  logic             of_q, of_d;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];

  logic [WIDTH-1:0] pc_plus_inc;
  logic [WIDTH-1:0] ras_top;
  logic [PW-1:0]    top_idx;
  logic             empty;
  logic             full;

  assign pc_plus_inc = pc_q + WIDTH'(INC);
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(RAS_DEPTH));
  assign top_idx     = ptr_q - PW'(1);
  assign ras_top     = empty ? '0 : mem_q[top_idx];

  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    uf_d    = 1'b0;
    of_d    = 1'b0;
    if (bus.flush) begin
      pc_d = bus.flush_target;
    end else if (!bus.stall) begin
      if (bus.branch_taken)
        pc_d = bus.branch_target;
      else if (bus.ret_pop && !empty)
        pc_d = ras_top;
      else
        pc_d = pc_plus_inc;

      // Push+pop on a live stack swaps the top in place; with an empty stack the
      // pop degrades to an underflow and the push goes ahead normally.
      if (bus.call_push && bus.ret_pop && !empty) begin
        mem_d[top_idx] = pc_plus_inc;
      end else begin
        if (bus.call_push) begin
          mem_d[ptr_q] = pc_plus_inc;
          ptr_d        = ptr_q + PW'(1);
          if (full)
            of_d = 1'b1;
          else
            count_d = count_q + CW'(1);
        end else if (bus.ret_pop && !empty) begin
          ptr_d   = top_idx;
          count_d = count_q - CW'(1);
        end
        if (bus.ret_pop && empty)
          uf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_VEC;
      ptr_q   <= '0;
      count_q <= '0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
    end
  end

  // Entry contents are don't-care after reset; only count/ptr define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.currPC        = pc_q;
  assign bus.pc_plus_inc   = pc_plus_inc;
  assign bus.ras_top       = ras_top;
  assign bus.ras_count     = count_q;
  assign bus.ras_empty     = empty;
  assign bus.ras_full      = full;
  assign bus.ras_underflow = uf_q;
  assign bus.ras_overflow  = of_q;
endmodule

// File: tb/tb_pc_fetch_ras.sv
// tb/tb_pc_fetch_ras.sv - scoreboard bench for pc_fetch_ras
module tb_pc_fetch_ras;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;

  pc_fetch_ras_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();

  pc_fetch_ras #(
    .WIDTH(WIDTH), .INC(4), .RESET_VEC(64'h400), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [63:0] pc;
    int          cnt;
    bit          uf;
    bit          of;
    bit          ctop;
    logic [63:0] top;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one DUT state per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("currPC", bus.currPC, e.pc);
        chk("pc_plus_inc", bus.pc_plus_inc, e.pc + 64'd4);
        chk("ras_count", 64'(bus.ras_count), 64'(e.cnt));
        chk("ras_empty", 64'(bus.ras_empty), 64'(e.cnt == 0));
        chk("ras_full", 64'(bus.ras_full), 64'(e.cnt == DEPTH));
        chk("ras_underflow", 64'(bus.ras_underflow), 64'(e.uf));
        chk("ras_overflow", 64'(bus.ras_overflow), 64'(e.of));
        if (e.ctop) chk("ras_top", bus.ras_top, e.top);
      end
    end
  end

  task automatic cyc(input bit r, input bit s, input bit f, input bit b,
                     input bit ps, input bit pp, input logic [63:0] tgt,
                     input logic [63:0] epc, input int ecnt, input bit euf, input bit eof,
                     input bit ctop = 1'b0, input logic [63:0] etop = 64'h0);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.stall         = s;
    bus.flush         = f;
    bus.flush_target  = tgt;
    bus.branch_taken  = b;
    bus.branch_target = tgt;
    bus.call_push     = ps;
    bus.ret_pop       = pp;
    e.pc = epc; e.cnt = ecnt; e.uf = euf; e.of = eof; e.ctop = ctop; e.top = etop;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.flush_target = '0;
    bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.call_push = 1'b0; bus.ret_pop = 1'b0;

    // reset and sequential fetch
    cyc(0,0,0,0,0,0, 64'h0, 64'h400, 0, 0, 0);
    cyc(0,0,0,0,0,0, 64'h0, 64'h400, 0, 0, 0, 1, 64'h0);
    cyc(1,0,0,0,0,0, 64'h0, 64'h404, 0, 0, 0);
    cyc(1,0,0,0,0,0, 64'h0, 64'h408, 0, 0, 0);
    cyc(1,0,0,0,0,0, 64'h0, 64'h40C, 0, 0, 0);
    // stall, flush over stall, branch over pop (pop on empty underflows)
    cyc(1,1,0,0,0,0, 64'h0, 64'h40C, 0, 0, 0);
    cyc(1,1,0,0,1,1, 64'h0, 64'h40C, 0, 0, 0);
    cyc(1,1,0,0,0,0, 64'h0, 64'h40C, 0, 0, 0);
    cyc(1,1,1,0,0,0, 64'h2000, 64'h2000, 0, 0, 0);
    cyc(1,0,0,1,0,1, 64'h3000, 64'h3000, 0, 1, 0);
    cyc(1,0,0,0,0,0, 64'h0, 64'h3004, 0, 0, 0);
    // call / return
    cyc(1,0,1,0,1,0, 64'h100, 64'h100, 0, 0, 0);
    cyc(1,0,0,1,1,0, 64'h800, 64'h800, 1, 0, 0, 1, 64'h104);
    cyc(1,0,0,0,0,0, 64'h0, 64'h804, 1, 0, 0);
    cyc(1,0,0,0,0,1, 64'h0, 64'h104, 0, 0, 0, 1, 64'h0);
    // simultaneous push+pop replaces top
    cyc(1,0,1,0,0,0, 64'h100, 64'h100, 0, 0, 0);
    cyc(1,0,0,1,1,0, 64'h300, 64'h300, 1, 0, 0, 1, 64'h104);
    cyc(1,0,0,0,1,1, 64'h0, 64'h104, 1, 0, 0, 1, 64'h304);
    cyc(1,0,0,0,0,1, 64'h0, 64'h304, 0, 0, 0);
    // nine pushes overflow a depth-8 stack, then drain and underflow
    cyc(1,0,1,0,0,0, 64'h0, 64'h0, 0, 0, 0);
    for (int k = 1; k <= 9; k++)
      cyc(1,0,0,0,1,0, 64'h0, 64'(4*k), (k > DEPTH) ? DEPTH : k, 0, k > DEPTH, 1, 64'(4*k));
    for (int k = 0; k < DEPTH; k++)
      cyc(1,0,0,0,0,1, 64'h0, 64'(36 - 4*k), DEPTH - 1 - k, 0, 0);
    cyc(1,0,0,0,0,1, 64'h0, 64'hC, 0, 1, 0);
    cyc(1,0,0,0,0,0, 64'h0, 64'h10, 0, 0, 0);
    // PC wrap, then reset mid-sequence with a non-empty stack
    cyc(1,0,1,0,0,0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
    cyc(1,0,0,0,0,0, 64'h0, 64'h0, 0, 0, 0);
    cyc(1,0,0,0,1,0, 64'h0, 64'h4, 1, 0, 0);
    cyc(1,0,0,0,1,0, 64'h0, 64'h8, 2, 0, 0);
    cyc(1,0,0,0,1,0, 64'h0, 64'hC, 3, 0, 0, 1, 64'hC);
    cyc(0,0,0,0,1,1, 64'h0, 64'h400, 0, 0, 0);
    cyc(1,0,0,0,0,0, 64'h0, 64'h404, 0, 0, 0);

    @(negedge clk);
    bus.call_push = 1'b0;
    bus.ret_pop   = 1'b0;
    for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
